// File: rtl/count_ctrl.sv
// Run/direction/record sequencer for the lab4 BCD counter, with clock-enable step tick and display scan.
// Define AUTO_REVERSE_EN to bounce off 00/99 instead of saturating.
module count_ctrl #(
    parameter int TICK_DIV = 33554432,
    parameter int SCAN_DIV = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_p,
    input  logic       dir_p,
    input  logic       rec_p,
    input  logic       at_max,
    input  logic       at_min,
    output logic       cnt_step,
    output logic       cnt_up,
    output logic       rec_load,
    output logic       running,
    output logic       max,
    output logic       min,
    output logic [1:0] scan_sel,
    output logic [3:0] digit
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cnt_step_q, cnt_step_d;
    logic          cnt_up_q, cnt_up_d;
    logic          dir_pend_q, dir_pend_d;
    logic          rec_load_q, rec_load_d;
    logic          running_q, running_d;
    logic          max_q, max_d;
    logic          min_q, min_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [1:0]    scan_sel_q, scan_sel_d;
    logic [3:0]    digit_q, digit_d;

    logic          up_eff;
    logic          terminal;
    logic          bnd;

    // A direction change that coincides with a step is held back one cycle so the
    // step is taken in the old direction; up_eff is the direction as of now.
    assign up_eff   = cnt_up_q ^ dir_pend_q;
    assign terminal = (tcnt_q == TICK_LAST);
    assign bnd      = (up_eff & at_max) | (~up_eff & at_min);

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        cnt_up_d   = up_eff;
        dir_pend_d = 1'b0;
        cnt_step_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en_p) begin
                    state_d = RUN;
                    tcnt_d  = '0;
                end
            end
            RUN: begin
                if (en_p) begin
                    state_d = PAUSE;
                end else begin
                    tcnt_d = terminal ? '0 : tcnt_q + 1'b1;
                    if (terminal && !bnd) begin
                        cnt_step_d = 1'b1;
                        dir_pend_d = dir_p;
                    end else if (terminal) begin
`ifdef AUTO_REVERSE_EN
                        cnt_up_d   = ~up_eff;
                        cnt_step_d = 1'b1;
`else
                        state_d    = SAT;
                        cnt_up_d   = up_eff ^ dir_p;
`endif
                    end else if (dir_p) begin
                        cnt_up_d = ~up_eff;
                    end
                end
            end
            PAUSE: begin
                if (en_p) state_d = RUN;
            end
            SAT: begin
                if (en_p) begin
                    state_d = PAUSE;
                    tcnt_d  = '0;
                end else if (dir_p) begin
                    state_d  = RUN;
                    tcnt_d   = '0;
                    cnt_up_d = ~up_eff;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d  = (state_d == RUN) || (state_d == SAT);
        max_d      = (state_d == SAT) &&  cnt_up_d;
        min_d      = (state_d == SAT) && !cnt_up_d;
        rec_load_d = rec_p && ((state_q == RUN) || (state_q == SAT));

        scnt_d     = (scnt_q == SCAN_LAST) ? '0 : scnt_q + 1'b1;
        scan_sel_d = (scnt_q == SCAN_LAST) ? scan_sel_q + 2'd1 : scan_sel_q;
        digit_d    = ~(4'b0001 << scan_sel_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            cnt_step_q <= 1'b0;
            cnt_up_q   <= 1'b1;
            dir_pend_q <= 1'b0;
            rec_load_q <= 1'b0;
            running_q  <= 1'b0;
            max_q      <= 1'b0;
            min_q      <= 1'b0;
            scnt_q     <= '0;
            scan_sel_q <= 2'd0;
            digit_q    <= 4'b1110;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            cnt_step_q <= cnt_step_d;
            cnt_up_q   <= cnt_up_d;
            dir_pend_q <= dir_pend_d;
            rec_load_q <= rec_load_d;
            running_q  <= running_d;
            max_q      <= max_d;
            min_q      <= min_d;
            scnt_q     <= scnt_d;
            scan_sel_q <= scan_sel_d;
            digit_q    <= digit_d;
        end
    end

    assign cnt_step = cnt_step_q;
    assign cnt_up   = cnt_up_q;
    assign rec_load = rec_load_q;
    assign running  = running_q;
    assign max      = max_q;
    assign min      = min_q;
    assign scan_sel = scan_sel_q;
    assign digit    = digit_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with TICK_DIV=4, SCAN_DIV=2; "cycle n" is the period after the n-th edge.
module tb_count_ctrl;

    logic       clk = 1'b0;
    logic       reset, en_p, dir_p, rec_p, at_max, at_min;
    logic       cnt_step, cnt_up, rec_load, running, max, min;
    logic [1:0] scan_sel;
    logic [3:0] digit;

    int n_run  = 0;
    int n_fail = 0;

    count_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .reset(reset), .en_p(en_p), .dir_p(dir_p), .rec_p(rec_p),
        .at_max(at_max), .at_min(at_min), .cnt_step(cnt_step), .cnt_up(cnt_up),
        .rec_load(rec_load), .running(running), .max(max), .min(min),
        .scan_sel(scan_sel), .digit(digit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en_p = 1'b1; rec_p = 1'b1; dir_p = 1'b1;
        tick();
        reset = 1'b0; en_p = 1'b0; rec_p = 1'b0; dir_p = 1'b0;
        n_run++; if (running !== 1'b0)  begin $display("FAIL reset_running: got %b want 0", running); n_fail++; end
        n_run++; if (cnt_up !== 1'b1)   begin $display("FAIL reset_cnt_up: got %b want 1", cnt_up); n_fail++; end
        n_run++; if (cnt_step !== 1'b0) begin $display("FAIL reset_cnt_step: got %b want 0", cnt_step); n_fail++; end
        n_run++; if (rec_load !== 1'b0) begin $display("FAIL reset_rec_load: got %b want 0", rec_load); n_fail++; end
        n_run++; if (max !== 1'b0 || min !== 1'b0) begin $display("FAIL reset_max_min: got %b%b want 00", max, min); n_fail++; end
        n_run++; if (scan_sel !== 2'd0) begin $display("FAIL reset_scan_sel: got %0d want 0", scan_sel); n_fail++; end
        n_run++; if (digit !== 4'b1110) begin $display("FAIL reset_digit: got %b want 1110", digit); n_fail++; end
        tick();
        n_run++; if (running !== 1'b0)  begin $display("FAIL idle_after_reset: got %b want 0", running); n_fail++; end
    endtask

    task automatic test_run();
        logic exp_step;
        do_reset();
        en_p = 1'b1;
        tick();
        en_p = 1'b0;
        n_run++; if (running !== 1'b1) begin $display("FAIL run_running: got %b want 1", running); n_fail++; end
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) tick();
            exp_step = (c == 5) || (c == 9) || (c == 13);
            n_run++;
            if (cnt_step !== exp_step) begin
                $display("FAIL run_step_c%0d: got %b want %b", c, cnt_step, exp_step); n_fail++;
            end
            n_run++;
            if (cnt_up !== 1'b1) begin $display("FAIL run_cnt_up_c%0d: got %b want 1", c, cnt_up); n_fail++; end
        end
    endtask

`ifndef AUTO_REVERSE_EN
    task automatic test_saturate();
        logic exp_b;
        do_reset();
        at_max = 1'b1;
        en_p   = 1'b1;
        tick();
        en_p = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            exp_b = (c == 5);
            n_run++; if (cnt_step !== 1'b0) begin $display("FAIL sat_no_step_c%0d: got %b want 0", c, cnt_step); n_fail++; end
            n_run++; if (max !== exp_b) begin $display("FAIL sat_max_c%0d: got %b want %b", c, max, exp_b); n_fail++; end
        end
        dir_p = 1'b1;
        tick();
        dir_p = 1'b0;
        n_run++; if (max !== 1'b0)     begin $display("FAIL sat_leave_max: got %b want 0", max); n_fail++; end
        n_run++; if (cnt_up !== 1'b0)  begin $display("FAIL sat_leave_cnt_up: got %b want 0", cnt_up); n_fail++; end
        n_run++; if (running !== 1'b1) begin $display("FAIL sat_leave_running: got %b want 1", running); n_fail++; end
        for (int c = 7; c <= 10; c++) begin
            tick();
            exp_b = (c == 10);
            n_run++; if (cnt_step !== exp_b) begin $display("FAIL sat_down_step_c%0d: got %b want %b", c, cnt_step, exp_b); n_fail++; end
        end
        at_min = 1'b1;
        for (int c = 11; c <= 14; c++) begin
            tick();
            exp_b = (c == 14);
            n_run++; if (cnt_step !== 1'b0) begin $display("FAIL sat_min_no_step_c%0d: got %b want 0", c, cnt_step); n_fail++; end
            n_run++; if (min !== exp_b) begin $display("FAIL sat_min_c%0d: got %b want %b", c, min, exp_b); n_fail++; end
        end
        n_run++; if (max !== 1'b0) begin $display("FAIL sat_min_max: got %b want 0", max); n_fail++; end
        en_p = 1'b1;
        tick();
        en_p = 1'b0;
        n_run++; if (running !== 1'b0 || min !== 1'b0) begin
            $display("FAIL sat_pause: got running=%b min=%b want 0 0", running, min); n_fail++;
        end
        at_max = 1'b0; at_min = 1'b0;
    endtask
`else
    task automatic test_auto_reverse();
        logic exp_b;
        do_reset();
        at_max = 1'b1;
        en_p   = 1'b1;
        tick();
        en_p = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            exp_b = (c == 5);
            n_run++; if (cnt_step !== exp_b) begin $display("FAIL rev_step_c%0d: got %b want %b", c, cnt_step, exp_b); n_fail++; end
            n_run++; if (cnt_up !== !exp_b) begin $display("FAIL rev_cnt_up_c%0d: got %b want %b", c, cnt_up, !exp_b); n_fail++; end
            n_run++; if (max !== 1'b0) begin $display("FAIL rev_max_c%0d: got %b want 0", c, max); n_fail++; end
        end
        at_max = 1'b0;
    endtask
`endif

    task automatic test_pause();
        logic seen;
        do_reset();
        en_p = 1'b1;
        tick();
        en_p = 1'b0;
        tick();
        tick();
        en_p = 1'b1;
        tick();
        en_p = 1'b0;
        n_run++; if (running !== 1'b0) begin $display("FAIL pause_running: got %b want 0", running); n_fail++; end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | cnt_step;
        end
        n_run++; if (seen !== 1'b0) begin $display("FAIL pause_no_step: got %b want 0", seen); n_fail++; end
        en_p = 1'b1;
        tick();
        en_p = 1'b0;
        n_run++; if (running !== 1'b1 || cnt_step !== 1'b0) begin
            $display("FAIL resume_k1: got running=%b step=%b want 1 0", running, cnt_step); n_fail++;
        end
        tick();
        n_run++; if (cnt_step !== 1'b0) begin $display("FAIL resume_k2: got %b want 0", cnt_step); n_fail++; end
        tick();
        n_run++; if (cnt_step !== 1'b1) begin $display("FAIL resume_k3: got %b want 1", cnt_step); n_fail++; end
        tick();
        n_run++; if (cnt_step !== 1'b0) begin $display("FAIL resume_k4: got %b want 0", cnt_step); n_fail++; end
    endtask

    task automatic test_record();
        do_reset();
        rec_p = 1'b1;
        tick();
        rec_p = 1'b0;
        n_run++; if (rec_load !== 1'b0) begin $display("FAIL rec_idle: got %b want 0", rec_load); n_fail++; end
        en_p = 1'b1; tick(); en_p = 1'b0;
        en_p = 1'b1; tick(); en_p = 1'b0;
        rec_p = 1'b1;
        tick();
        rec_p = 1'b0;
        n_run++; if (rec_load !== 1'b0 || running !== 1'b0) begin
            $display("FAIL rec_pause: got rec_load=%b running=%b want 0 0", rec_load, running); n_fail++;
        end
        en_p = 1'b1; tick(); en_p = 1'b0;
        rec_p = 1'b1;
        tick();
        rec_p = 1'b0;
        n_run++; if (rec_load !== 1'b1) begin $display("FAIL rec_run: got %b want 1", rec_load); n_fail++; end
        tick();
        n_run++; if (rec_load !== 1'b0) begin $display("FAIL rec_run_single: got %b want 0", rec_load); n_fail++; end
        rec_p = 1'b1;
        tick();
        n_run++; if (rec_load !== 1'b1) begin $display("FAIL rec_b2b_first: got %b want 1", rec_load); n_fail++; end
        tick();
        rec_p = 1'b0;
        n_run++; if (rec_load !== 1'b1) begin $display("FAIL rec_b2b_second: got %b want 1", rec_load); n_fail++; end
        tick();
        n_run++; if (rec_load !== 1'b0) begin $display("FAIL rec_b2b_end: got %b want 0", rec_load); n_fail++; end
        rec_p = 1'b1; en_p = 1'b1;
        tick();
        rec_p = 1'b0; en_p = 1'b0;
        n_run++; if (rec_load !== 1'b1 || running !== 1'b0) begin
            $display("FAIL rec_with_en: got rec_load=%b running=%b want 1 0", rec_load, running); n_fail++;
        end
        tick();
        n_run++; if (rec_load !== 1'b0) begin $display("FAIL rec_with_en_end: got %b want 0", rec_load); n_fail++; end
    endtask

    task automatic test_direction();
        do_reset();
        en_p = 1'b1; tick(); en_p = 1'b0;
        tick();
        en_p = 1'b1; dir_p = 1'b1;
        tick();
        en_p = 1'b0; dir_p = 1'b0;
        n_run++; if (running !== 1'b0 || cnt_up !== 1'b1) begin
            $display("FAIL dir_en_same: got running=%b cnt_up=%b want 0 1", running, cnt_up); n_fail++;
        end
        en_p = 1'b1; tick(); en_p = 1'b0;
        tick();
        tick();
        dir_p = 1'b1;
        tick();
        dir_p = 1'b0;
        n_run++; if (cnt_step !== 1'b1 || cnt_up !== 1'b1) begin
            $display("FAIL dir_term_step: got step=%b cnt_up=%b want 1 1", cnt_step, cnt_up); n_fail++;
        end
        tick();
        n_run++; if (cnt_step !== 1'b0 || cnt_up !== 1'b0) begin
            $display("FAIL dir_term_flip: got step=%b cnt_up=%b want 0 0", cnt_step, cnt_up); n_fail++;
        end
        dir_p = 1'b1;
        tick();
        dir_p = 1'b0;
        n_run++; if (cnt_up !== 1'b1) begin $display("FAIL dir_plain_toggle: got %b want 1", cnt_up); n_fail++; end
    endtask

    task automatic test_scan();
        logic [3:0] exp_digit [5];
        exp_digit[0] = 4'b1110; exp_digit[1] = 4'b1101; exp_digit[2] = 4'b1011;
        exp_digit[3] = 4'b0111; exp_digit[4] = 4'b1110;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (digit !== exp_digit[i]) begin
                $display("FAIL scan_digit_%0d: got %b want %b", i, digit, exp_digit[i]); n_fail++;
            end
            n_run++;
            if (scan_sel !== 2'(i)) begin
                $display("FAIL scan_sel_%0d: got %0d want %0d", i, scan_sel, 2'(i)); n_fail++;
            end
            tick();
            n_run++;
            if (digit !== exp_digit[i]) begin
                $display("FAIL scan_hold_%0d: got %b want %b", i, digit, exp_digit[i]); n_fail++;
            end
            tick();
        end
        tick();
        tick();
        tick();
        en_p = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; en_p = 1'b0;
        n_run++; if (digit !== 4'b1110 || scan_sel !== 2'd0) begin
            $display("FAIL scan_mid_reset: got digit=%b sel=%0d want 1110 0", digit, scan_sel); n_fail++;
        end
        n_run++; if (running !== 1'b0) begin $display("FAIL scan_reset_en: got %b want 0", running); n_fail++; end
    endtask

    initial begin
        reset = 1'b1; en_p = 1'b0; dir_p = 1'b0; rec_p = 1'b0; at_max = 1'b0; at_min = 1'b0;
        tick();
        test_reset();
        test_run();
`ifndef AUTO_REVERSE_EN
        test_saturate();
`else
        test_auto_reverse();
`endif
        test_pause();
        test_record();
        test_direction();
        test_scan();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
